// File: rtl/writeback_commit_arbiter_pkg.sv
// rtl/writeback_commit_arbiter_pkg.sv - shared core types for the writeback commit path
package writeback_commit_arbiter_pkg;

   localparam int TAG_W  = 4;
   localparam int WORD_W = 32;

   typedef logic [TAG_W-1:0]  RegTag;
   typedef logic [WORD_W-1:0] Word;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } StatusFlags;

   // All-ones tag is reserved to mean "this slot carries no register write".
   localparam RegTag NULL_REG_TAG = {TAG_W{1'b1}};

   typedef struct packed {
      RegTag      resultRegTag;
      Word        resultValue;
      RegTag      autoIncRegTag;
      Word        autoIncValue;
      StatusFlags psrValue;
      logic       psrUpdated;
   } WbSignals;

   typedef enum logic {
      IDLE,
      SECOND
   } CommitState;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_RESULT,
      WB_AUTOINC,
      WB_DUAL
   } WbClass;

   // Equal non-null tags collapse to a result-only write; the result wins.
   function automatic WbClass classify(input RegTag resultTag, input RegTag autoIncTag);
      logic hasResult;
      logic hasAutoInc;
      hasResult  = (resultTag != NULL_REG_TAG);
      hasAutoInc = (autoIncTag != NULL_REG_TAG);
      if (hasResult && hasAutoInc && (resultTag != autoIncTag)) return WB_DUAL;
      if (hasResult)                                           return WB_RESULT;
      if (hasAutoInc)                                          return WB_AUTOINC;
      return WB_NONE;
   endfunction

endpackage

// File: rtl/writeback_commit_arbiter_sat_counter16.sv
// rtl/writeback_commit_arbiter_sat_counter16.sv - 16-bit saturating event counter
module sat_counter16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   output logic [15:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 16'h0000;
      end else if (inc && (count != 16'hFFFF)) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/writeback_commit_arbiter.sv
// rtl/writeback_commit_arbiter.sv - serialises dual writeback bundles onto one register-file write port
module writeback_commit_arbiter
   import writeback_commit_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inValid,
   output logic       inReady,
   input  WbSignals   inSignals,
   output logic       rfWriteEnable,
   output RegTag      rfWriteTag,
   output Word        rfWriteValue,
   output logic       psrWriteEnable,
   output StatusFlags psrWriteValue,
   output logic [15:0] stallCount
);

   CommitState state;
   RegTag      heldTag;
   Word        heldValue;
   WbClass     wbClass;

   assign wbClass = classify(inSignals.resultRegTag, inSignals.autoIncRegTag);
   assign inReady = (state == IDLE) && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         heldTag        <= NULL_REG_TAG;
         heldValue      <= '0;
         rfWriteEnable  <= 1'b0;
         rfWriteTag     <= NULL_REG_TAG;
         rfWriteValue   <= '0;
         psrWriteEnable <= 1'b0;
         psrWriteValue  <= '0;
      end else begin
         rfWriteEnable  <= 1'b0;
         psrWriteEnable <= 1'b0;
         case (state)
            IDLE: begin
               if (inValid) begin
                  psrWriteEnable <= inSignals.psrUpdated;
                  if (inSignals.psrUpdated) psrWriteValue <= inSignals.psrValue;
                  case (wbClass)
                     // autoInc goes first so the result is the last value seen for its tag
                     WB_DUAL: begin
                        rfWriteEnable <= 1'b1;
                        rfWriteTag    <= inSignals.autoIncRegTag;
                        rfWriteValue  <= inSignals.autoIncValue;
                        heldTag       <= inSignals.resultRegTag;
                        heldValue     <= inSignals.resultValue;
                        state         <= SECOND;
                     end
                     WB_RESULT: begin
                        rfWriteEnable <= 1'b1;
                        rfWriteTag    <= inSignals.resultRegTag;
                        rfWriteValue  <= inSignals.resultValue;
                     end
                     WB_AUTOINC: begin
                        rfWriteEnable <= 1'b1;
                        rfWriteTag    <= inSignals.autoIncRegTag;
                        rfWriteValue  <= inSignals.autoIncValue;
                     end
                     default: ;
                  endcase
               end
            end
            SECOND: begin
               rfWriteEnable <= 1'b1;
               rfWriteTag    <= heldTag;
               rfWriteValue  <= heldValue;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   sat_counter16 uStallCounter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inValid && !inReady),
      .count (stallCount)
   );

endmodule

// File: tb/tb_writeback_commit_arbiter.sv
// tb/tb_writeback_commit_arbiter.sv - directed bench for writeback_commit_arbiter
module tb_writeback_commit_arbiter;
   import writeback_commit_arbiter_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       inValid;
   logic       inReady;
   WbSignals   inSignals;
   logic       rfWriteEnable;
   RegTag      rfWriteTag;
   Word        rfWriteValue;
   logic       psrWriteEnable;
   StatusFlags psrWriteValue;
   logic [15:0] stallCount;

   int total = 0;
   int bad   = 0;

   writeback_commit_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .inValid        (inValid),
      .inReady        (inReady),
      .inSignals      (inSignals),
      .rfWriteEnable  (rfWriteEnable),
      .rfWriteTag     (rfWriteTag),
      .rfWriteValue   (rfWriteValue),
      .psrWriteEnable (psrWriteEnable),
      .psrWriteValue  (psrWriteValue),
      .stallCount     (stallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic WbSignals mk(input RegTag rt, input Word rv, input RegTag at, input Word av,
                                   input logic pu, input logic [3:0] pv);
      WbSignals s;
      s.resultRegTag  = rt;
      s.resultValue   = rv;
      s.autoIncRegTag = at;
      s.autoIncValue  = av;
      s.psrUpdated    = pu;
      s.psrValue      = StatusFlags'(pv);
      return s;
   endfunction

   task automatic checkWrite(input string tag, input logic en, input RegTag t, input Word v);
      check({tag, ".rfWe"}, 32'(rfWriteEnable), 32'(en));
      if (en) begin
         check({tag, ".rfTag"}, 32'(rfWriteTag), 32'(t));
         check({tag, ".rfVal"}, rfWriteValue, v);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, ".rfWe"},   32'(rfWriteEnable),  32'd0);
      check({tag, ".rfTag"},  32'(rfWriteTag),     32'(NULL_REG_TAG));
      check({tag, ".rfVal"},  rfWriteValue,        32'd0);
      check({tag, ".psrWe"},  32'(psrWriteEnable), 32'd0);
      check({tag, ".psrVal"}, 32'(psrWriteValue),  32'd0);
      check({tag, ".stall"},  32'(stallCount),     32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      inValid   = 1'b0;
      inSignals = mk(NULL_REG_TAG, 32'd0, NULL_REG_TAG, 32'd0, 1'b0, 4'h0);

      // reset state
      tick();
      checkResetOutputs("rst");
      check("rst.inReady", 32'(inReady), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("idle.inReady", 32'(inReady), 32'd1);

      // result r3 only, PSR update
      inValid   = 1'b1;
      inSignals = mk(4'd3, 32'h11, NULL_REG_TAG, 32'h0, 1'b1, 4'hA);
      tick();
      inValid = 1'b0;
      checkWrite("single", 1'b1, 4'd3, 32'h11);
      check("single.psrWe",   32'(psrWriteEnable), 32'd1);
      check("single.psrVal",  32'(psrWriteValue),  32'hA);
      check("single.inReady", 32'(inReady),        32'd1);
      tick();
      checkWrite("single.after", 1'b0, 4'd0, 32'd0);
      check("single.after.psrWe", 32'(psrWriteEnable), 32'd0);

      // DUAL: autoInc r5 first, then result r2
      inValid   = 1'b1;
      inSignals = mk(4'd2, 32'hAA, 4'd5, 32'h40, 1'b0, 4'h0);
      tick();
      inValid = 1'b0;
      checkWrite("dual.c1", 1'b1, 4'd5, 32'h40);
      check("dual.c1.psrWe",   32'(psrWriteEnable), 32'd0);
      check("dual.c1.inReady", 32'(inReady),        32'd0);
      tick();
      checkWrite("dual.c2", 1'b1, 4'd2, 32'hAA);
      check("dual.c2.inReady", 32'(inReady), 32'd1);
      tick();
      checkWrite("dual.c3", 1'b0, 4'd0, 32'd0);
      check("dual.stall", 32'(stallCount), 32'd0);

      // equal tags: result only
      inValid   = 1'b1;
      inSignals = mk(4'd4, 32'h1, 4'd4, 32'h2, 1'b0, 4'h0);
      tick();
      inValid = 1'b0;
      checkWrite("same", 1'b1, 4'd4, 32'h1);
      check("same.inReady", 32'(inReady), 32'd1);
      tick();
      checkWrite("same.after", 1'b0, 4'd0, 32'd0);

      // continuous valid: DUAL, SINGLE(autoInc only), DUAL
      inValid   = 1'b1;
      inSignals = mk(4'd1, 32'h101, 4'd7, 32'h107, 1'b0, 4'h0);
      tick();
      checkWrite("seq.a1", 1'b1, 4'd7, 32'h107);
      check("seq.a1.inReady", 32'(inReady), 32'd0);
      tick();
      checkWrite("seq.a2", 1'b1, 4'd1, 32'h101);
      check("seq.a2.stall", 32'(stallCount), 32'd1);
      inSignals = mk(NULL_REG_TAG, 32'h0, 4'd9, 32'h9, 1'b1, 4'h5);
      tick();
      checkWrite("seq.b", 1'b1, 4'd9, 32'h9);
      check("seq.b.psrWe",  32'(psrWriteEnable), 32'd1);
      check("seq.b.psrVal", 32'(psrWriteValue),  32'h5);
      inSignals = mk(4'd6, 32'h66, 4'd8, 32'h88, 1'b0, 4'h0);
      tick();
      checkWrite("seq.c1", 1'b1, 4'd8, 32'h88);
      check("seq.c1.psrWe", 32'(psrWriteEnable), 32'd0);
      tick();
      inValid = 1'b0;
      checkWrite("seq.c2", 1'b1, 4'd6, 32'h66);
      tick();
      checkWrite("seq.end", 1'b0, 4'd0, 32'd0);
      check("seq.stall", 32'(stallCount), 32'd2);

      // NONE: both null
      inValid   = 1'b1;
      inSignals = mk(NULL_REG_TAG, 32'h5, NULL_REG_TAG, 32'h6, 1'b0, 4'h0);
      tick();
      inValid = 1'b0;
      checkWrite("none", 1'b0, 4'd0, 32'd0);
      check("none.inReady", 32'(inReady), 32'd1);

      // reset while holding the result of a DUAL
      inValid   = 1'b1;
      inSignals = mk(4'd1, 32'h1, 4'd6, 32'h6, 1'b0, 4'h0);
      tick();
      inValid = 1'b0;
      checkWrite("rdual.c1", 1'b1, 4'd6, 32'h6);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("rdual.async");
      check("rdual.async.inReady", 32'(inReady), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      checkResetOutputs("rdual.rel1");
      check("rdual.rel1.inReady", 32'(inReady), 32'd1);
      tick();
      checkResetOutputs("rdual.rel2");

      // saturation: preload near the limit, then three stall cycles
      force dut.uStallCounter.count = 16'hFFFE;
      #1;
      release dut.uStallCounter.count;
      #1;
      check("sat.preload", 32'(stallCount), 32'hFFFE);
      inValid   = 1'b1;
      inSignals = mk(4'd2, 32'h22, 4'd3, 32'h33, 1'b0, 4'h0);
      tick();
      tick();
      check("sat.first", 32'(stallCount), 32'hFFFF);
      tick();
      tick();
      tick();
      tick();
      inValid = 1'b0;
      check("sat.hold", 32'(stallCount), 32'hFFFF);
      tick();
      check("sat.idle", 32'(stallCount), 32'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
